// File: rtl/fcc_union_find.sv
// fcc_union_find: union-find responder that keeps a parent table of provisional labels,
// merges label pairs and resolves root queries. Revision 1.0
`default_nettype none

module fcc_union_find #(
  parameter int LABEL_W    = 16,
  parameter int MAX_LABELS = 1024,
  parameter int IDX_W      = 10,
  parameter int MAX_HOPS   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               merge_valid,
  input  logic [LABEL_W-1:0] merge_a,
  input  logic [LABEL_W-1:0] merge_b,
  output logic               merge_ready,
  input  logic               q_valid,
  input  logic [LABEL_W-1:0] q_label,
  output logic               q_ready,
  output logic               q_out_valid,
  output logic [LABEL_W-1:0] q_root,
  output logic               busy,
  output logic               range_err
);

  localparam int                 HOP_W    = $clog2(MAX_HOPS + 1);
  localparam logic [LABEL_W:0]   LIMIT    = (LABEL_W + 1)'(MAX_LABELS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(MAX_LABELS - 1);
  localparam logic [HOP_W-1:0]   HOP_MAX  = HOP_W'(MAX_HOPS);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_FIND_A, S_FIND_B, S_LINK, S_Q_FIND, S_Q_OUT
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]   parent [MAX_LABELS];
  logic [IDX_W-1:0]   init_cnt;
  logic [LABEL_W-1:0] a_lbl, b_lbl, ra, rb, cur, ql_label;
  logic [HOP_W-1:0]   hop_cnt;
  logic               ql_full;

  logic [LABEL_W-1:0] par_lbl, lo, hi;
  logic               cur_ok, a_ok, b_ok, hop_lim, at_root, walking;
  logic               accept_m, accept_q;

  assign merge_ready = (state == S_IDLE) && !ql_full;
  assign q_ready     = merge_ready;
  assign busy        = (state != S_IDLE) || ql_full;
  assign accept_m    = merge_valid && merge_ready;
  assign accept_q    = q_valid && q_ready;

  // Out-of-range labels behave as their own roots and never touch the table
  assign cur_ok  = {1'b0, cur} < LIMIT;
  assign a_ok    = {1'b0, a_lbl} < LIMIT;
  assign b_ok    = {1'b0, b_lbl} < LIMIT;
  assign par_lbl = LABEL_W'(parent[cur[IDX_W-1:0]]);
  assign hop_lim = (hop_cnt == HOP_MAX);
  assign at_root = !cur_ok || (par_lbl == cur) || hop_lim;
  assign walking = (state == S_FIND_A) || (state == S_FIND_B) || (state == S_Q_FIND);
  assign lo      = (ra < rb) ? ra : rb;
  assign hi      = (ra < rb) ? rb : ra;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:   if (init_cnt == LAST_IDX) state_nxt = S_IDLE;
      S_IDLE: begin
        if (accept_m)      state_nxt = S_FIND_A;
        else if (accept_q) state_nxt = S_Q_FIND;
      end
      S_FIND_A: if (at_root) state_nxt = S_FIND_B;
      S_FIND_B: if (at_root) state_nxt = S_LINK;
      S_LINK:   state_nxt = ql_full ? S_Q_FIND : S_IDLE;
      S_Q_FIND: if (at_root) state_nxt = S_Q_OUT;
      S_Q_OUT:  state_nxt = S_IDLE;
      default:  state_nxt = S_INIT;
    endcase
  end

  // Table is rebuilt by the INIT sweep after every reset, so it carries no reset itself
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      parent[init_cnt] <= init_cnt;
    end else if (state == S_LINK && a_ok && b_ok) begin
      parent[hi[IDX_W-1:0]]    <= lo[IDX_W-1:0];
      parent[a_lbl[IDX_W-1:0]] <= lo[IDX_W-1:0];
      parent[b_lbl[IDX_W-1:0]] <= lo[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt    <= '0;
      a_lbl       <= '0;
      b_lbl       <= '0;
      ra          <= '0;
      rb          <= '0;
      cur         <= '0;
      hop_cnt     <= '0;
      ql_full     <= 1'b0;
      ql_label    <= '0;
      q_out_valid <= 1'b0;
      q_root      <= '0;
      range_err   <= 1'b0;
    end else begin
      q_out_valid <= 1'b0;
      if (walking) begin
        if (at_root) begin
          hop_cnt <= '0;
          if (!cur_ok || hop_lim) range_err <= 1'b1;
        end else begin
          cur     <= par_lbl;
          hop_cnt <= hop_cnt + 1'b1;
        end
      end
      case (state)
        S_INIT: init_cnt <= init_cnt + 1'b1;
        S_IDLE: begin
          if (accept_m) begin
            a_lbl   <= merge_a;
            b_lbl   <= merge_b;
            cur     <= merge_a;
            hop_cnt <= '0;
            if (accept_q) begin
              ql_full  <= 1'b1;
              ql_label <= q_label;
            end
          end else if (accept_q) begin
            cur     <= q_label;
            hop_cnt <= '0;
          end
        end
        S_FIND_A: if (at_root) begin
          ra  <= cur;
          cur <= b_lbl;
        end
        S_FIND_B: if (at_root) rb <= cur;
        S_LINK: if (ql_full) begin
          cur     <= ql_label;
          hop_cnt <= '0;
          ql_full <= 1'b0;
        end
        S_Q_FIND: if (at_root) q_root <= cur;
        S_Q_OUT:  q_out_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fcc_union_find.sv
// tb_fcc_union_find: directed merges/queries; a monitor checks every q_out_valid pulse
// against a queue of expected roots and latencies.
`default_nettype none

module tb_fcc_union_find;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        merge_valid = 1'b0;
  logic [15:0] merge_a = '0;
  logic [15:0] merge_b = '0;
  logic        merge_ready;
  logic        q_valid = 1'b0;
  logic [15:0] q_label = '0;
  logic        q_ready;
  logic        q_out_valid;
  logic [15:0] q_root;
  logic        busy;
  logic        range_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int root;
    int t;
    int lat;
  } exp_t;
  exp_t sb[$];

  fcc_union_find dut (
    .clk(clk), .rst(rst),
    .merge_valid(merge_valid), .merge_a(merge_a), .merge_b(merge_b), .merge_ready(merge_ready),
    .q_valid(q_valid), .q_label(q_label), .q_ready(q_ready),
    .q_out_valid(q_out_valid), .q_root(q_root), .busy(busy), .range_err(range_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the oldest expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_q_out", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("q_root", int'(q_root), e.root);
          chk("q_latency", cyc - e.t, e.lat);
        end
      end
    end
  end

  task automatic wait_ready(output int n);
    n = 0;
    while (!merge_ready && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", n < 200 ? 1 : 0, 1);
  endtask

  task automatic do_merge(input int a, input int b, input int occ);
    int n;
    merge_valid = 1'b1;
    merge_a     = 16'(a);
    merge_b     = 16'(b);
    @(posedge clk);
    #1;
    merge_valid = 1'b0;
    wait_ready(n);
    chk($sformatf("merge_occ_%0d_%0d", a, b), n, occ);
  endtask

  task automatic do_query(input int lbl, input int root, input int lat);
    exp_t e;
    q_valid = 1'b1;
    q_label = 16'(lbl);
    @(posedge clk);
    #1;
    q_valid = 1'b0;
    e.root = root; e.t = cyc; e.lat = lat;
    sb.push_back(e);
    wait_idle();
  endtask

  initial begin
    int n;
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_merge_ready", int'(merge_ready), 0);
    chk("rst_q_ready", int'(q_ready), 0);
    chk("rst_q_out_valid", int'(q_out_valid), 0);
    chk("rst_q_root", int'(q_root), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_range_err", int'(range_err), 0);
    rst = 1'b0;
    wait_ready(n);
    chk("init_cycles", n, 1024);

    do_query(37, 37, 2);
    do_query(0, 0, 2);

    do_merge(5, 9, 3);
    do_query(9, 5, 3);
    do_query(5, 5, 2);

    do_merge(10, 20, 3);
    do_merge(20, 30, 4);
    do_merge(30, 40, 4);
    do_query(20, 10, 3);
    do_query(30, 10, 3);
    do_query(40, 10, 3);

    // Same-cycle merge and query: query is served after the link completes
    merge_valid = 1'b1; merge_a = 16'd3; merge_b = 16'd7;
    q_valid = 1'b1; q_label = 16'd7;
    @(posedge clk);
    #1;
    merge_valid = 1'b0; q_valid = 1'b0;
    e.root = 3; e.t = cyc; e.lat = 6;
    sb.push_back(e);
    wait_idle();

    chk("range_err_before", int'(range_err), 0);
    do_merge(2000, 4, 3);
    chk("range_err_after", int'(range_err), 1);
    do_query(2000, 2000, 2);
    do_query(4, 4, 2);

    // Reset during FIND_A aborts the merge and rebuilds the table
    merge_valid = 1'b1; merge_a = 16'd100; merge_b = 16'd50;
    @(posedge clk);
    #1;
    merge_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_merge_ready", int'(merge_ready), 0);
    chk("midrst_busy", int'(busy), 1);
    chk("midrst_range_err", int'(range_err), 0);
    chk("midrst_q_root", int'(q_root), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ready(n);
    chk("reinit_cycles", n, 1024);
    do_query(100, 100, 2);
    do_query(50, 50, 2);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
